// File: rtl/mmio_ports_if.sv
// Bus-side interface of the memory-mapped I/O port block.
// The register file drives the address, data and strobes (master);
// the port block returns read data and the window hit (slave).
interface mmio_ports_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] ADDRESS;
  logic [DATA_W-1:0] WDATA;
  logic              STORE;
  logic              LOAD;
  logic [DATA_W-1:0] RDATA;
  logic              HIT;

  modport master (
    output ADDRESS, WDATA, STORE, LOAD,
    input  RDATA, HIT
  );

  modport slave (
    input  ADDRESS, WDATA, STORE, LOAD,
    output RDATA, HIT
  );
endinterface

// File: rtl/mmio_ports.sv
// Memory-mapped I/O ports: N_OUT writable output registers, N_IN
// synchronized input channels with sticky change flags (write-1-to-clear),
// an interrupt enable mask and a registered interrupt request.
// Window layout from BASE_ADDR: OUT[0..N_OUT-1], IN[0..N_IN-1], CHG, IEN.
module mmio_ports #(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'hFF00,
  parameter int                N_OUT       = 3,
  parameter int                N_IN        = 2,
  parameter int                SYNC_STAGES = 2
) (
  input  logic                    CLK,
  input  logic                    RESET,
  mmio_ports_if.slave             bus,
  input  logic [N_IN*DATA_W-1:0]  IN_PORTS,
  output logic [N_OUT*DATA_W-1:0] OUT_PORTS,
  output logic                    IRQ
);

  localparam int                WIN     = N_OUT + N_IN + 2;
  localparam logic [ADDR_W-1:0] OFF_CHG = ADDR_W'(N_OUT + N_IN);
  localparam logic [ADDR_W-1:0] OFF_IEN = ADDR_W'(N_OUT + N_IN + 1);

  logic [ADDR_W-1:0] offset;
  logic              hit;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] in_mask;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] chg_set;
  logic [DATA_W-1:0] chg_clr;

  logic [DATA_W-1:0] out_q  [N_OUT];
  logic [DATA_W-1:0] out_d  [N_OUT];
  logic [DATA_W-1:0] sync_q [N_IN][SYNC_STAGES];
  logic [DATA_W-1:0] sync_d [N_IN][SYNC_STAGES];
  logic [DATA_W-1:0] hist_q [N_IN];
  logic [DATA_W-1:0] hist_d [N_IN];
  logic [DATA_W-1:0] chg_q, chg_d;
  logic [DATA_W-1:0] ien_q, ien_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              irq_q, irq_d;

  // Address decode: offset wraps modulo 2^ADDR_W, so addresses below the base never hit.
  always_comb begin
    offset = bus.ADDRESS - BASE_ADDR;
    hit    = (offset < ADDR_W'(WIN));
    wr_en  = bus.STORE & hit;
    rd_en  = bus.LOAD & ~bus.STORE;
    for (int i = 0; i < DATA_W; i++) begin
      in_mask[i] = (i < N_IN);
    end
  end

  // Read multiplexer over the whole window; IN reads the last synchronizer stage.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (offset == ADDR_W'(k)) rd_mux = out_q[k];
    end
    for (int k = 0; k < N_IN; k++) begin
      if (offset == ADDR_W'(N_OUT + k)) rd_mux = sync_q[k][SYNC_STAGES-1];
    end
    if (offset == OFF_CHG) rd_mux = chg_q;
    if (offset == OFF_IEN) rd_mux = ien_q;
  end

  // Next-state for output registers, synchronizers, history and change flags.
  always_comb begin
    chg_set = '0;
    for (int k = 0; k < N_OUT; k++) begin
      out_d[k] = out_q[k];
      if (wr_en && offset == ADDR_W'(k)) out_d[k] = bus.WDATA;
    end
    for (int k = 0; k < N_IN; k++) begin
      sync_d[k][0] = IN_PORTS[k*DATA_W +: DATA_W];
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_d[k][s] = sync_q[k][s-1];
      end
      hist_d[k]  = sync_q[k][SYNC_STAGES-1];
      chg_set[k] = (sync_q[k][SYNC_STAGES-1] != hist_q[k]);
    end
    chg_clr = (wr_en && offset == OFF_CHG) ? (bus.WDATA & in_mask) : '0;
    chg_d   = ((chg_q & ~chg_clr) | chg_set) & in_mask;
    ien_d   = (wr_en && offset == OFF_IEN) ? (bus.WDATA & in_mask) : ien_q;
    irq_d   = |(chg_q & ien_q);
    rdata_d = rdata_q;
    if (rd_en) rdata_d = hit ? rd_mux : '0;
  end

  // State registers; reset clears every flop and drops any access in flight.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
      for (int k = 0; k < N_IN; k++) begin
        for (int s = 0; s < SYNC_STAGES; s++) sync_q[k][s] <= '0;
        hist_q[k] <= '0;
      end
      chg_q   <= '0;
      ien_q   <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      for (int k = 0; k < N_OUT; k++) out_q[k] <= out_d[k];
      for (int k = 0; k < N_IN; k++) begin
        for (int s = 0; s < SYNC_STAGES; s++) sync_q[k][s] <= sync_d[k][s];
        hist_q[k] <= hist_d[k];
      end
      chg_q   <= chg_d;
      ien_q   <= ien_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  // Output packing: channel k occupies bits [k*DATA_W +: DATA_W].
  always_comb begin
    OUT_PORTS = '0;
    for (int k = 0; k < N_OUT; k++) begin
      OUT_PORTS[k*DATA_W +: DATA_W] = out_q[k];
    end
  end

  assign bus.HIT   = hit;
  assign bus.RDATA = rdata_q;
  assign IRQ       = irq_q;

endmodule

// File: tb/tb_mmio_ports.sv
// Directed bench for mmio_ports with default parameters; expected values
// are queued when stimulus is applied and popped when outputs are sampled.
module tb_mmio_ports;
  localparam int DATA_W      = 8;
  localparam int ADDR_W      = 16;
  localparam int N_OUT       = 3;
  localparam int N_IN        = 2;
  localparam int SYNC_STAGES = 2;

  localparam logic [15:0] A_OUT0 = 16'hFF00;
  localparam logic [15:0] A_OUT1 = 16'hFF01;
  localparam logic [15:0] A_OUT2 = 16'hFF02;
  localparam logic [15:0] A_IN0  = 16'hFF03;
  localparam logic [15:0] A_CHG  = 16'hFF05;
  localparam logic [15:0] A_IEN  = 16'hFF06;
  localparam logic [15:0] A_END  = 16'hFF07;
  localparam logic [15:0] A_BELOW = 16'hFEFF;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] IN_PORTS;
  logic [23:0] OUT_PORTS;
  logic        IRQ;

  mmio_ports_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mmio_ports #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(16'hFF00),
    .N_OUT(N_OUT), .N_IN(N_IN), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus.slave),
    .IN_PORTS(IN_PORTS),
    .OUT_PORTS(OUT_PORTS),
    .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic expect_val(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check_output(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("[TB] FAIL scoreboard_empty observed=%0h expected=none", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
    end
  endtask

  task automatic do_store(input logic [15:0] addr, input logic [7:0] data);
    @(negedge CLK);
    bus.ADDRESS = addr;
    bus.WDATA   = data;
    bus.STORE   = 1'b1;
    bus.LOAD    = 1'b0;
    @(negedge CLK);
    bus.STORE   = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] addr);
    @(negedge CLK);
    bus.ADDRESS = addr;
    bus.STORE   = 1'b0;
    bus.LOAD    = 1'b1;
    @(negedge CLK);
    bus.LOAD    = 1'b0;
  endtask

  initial begin
    RESET       = 1'b0;
    IN_PORTS    = '0;
    bus.ADDRESS = A_OUT0;
    bus.WDATA   = '0;
    bus.STORE   = 1'b0;
    bus.LOAD    = 1'b0;
    #12;

    $display("[TB] reset state");
    expect_val("reset_out_ports", 32'h0); check_output(32'(OUT_PORTS));
    expect_val("reset_rdata", 32'h0);     check_output(32'(bus.RDATA));
    expect_val("reset_irq", 32'h0);       check_output(32'(IRQ));
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);

    $display("[TB] output port store and read");
    expect_val("out1_store", 32'h00A500);
    do_store(A_OUT1, 8'hA5);
    check_output(32'(OUT_PORTS));
    @(negedge CLK);
    bus.ADDRESS = A_OUT1;
    bus.LOAD    = 1'b1;
    #1;
    expect_val("hit_out1", 32'h1); check_output(32'(bus.HIT));
    @(negedge CLK);
    bus.LOAD = 1'b0;
    expect_val("read_out1", 32'hA5); check_output(32'(bus.RDATA));
    do_store(A_OUT0, 8'h11);
    do_store(A_OUT2, 8'h22);
    expect_val("out_all", 32'h22A511); check_output(32'(OUT_PORTS));

    $display("[TB] interrupt enable register");
    do_store(A_IEN, 8'hFF);
    do_load(A_IEN);
    expect_val("ien_masked", 32'h03); check_output(32'(bus.RDATA));
    do_store(A_IEN, 8'h01);
    do_load(A_CHG);
    expect_val("chg_idle", 32'h00); check_output(32'(bus.RDATA));

    $display("[TB] input change detection latency");
    @(negedge CLK);
    IN_PORTS[7:0] = 8'h3C;
    bus.ADDRESS   = A_IN0;
    bus.LOAD      = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    expect_val("in0_not_yet", 32'h00); check_output(32'(bus.RDATA));
    @(negedge CLK);
    bus.LOAD = 1'b0;
    expect_val("in0_synced", 32'h3C); check_output(32'(bus.RDATA));
    expect_val("irq_lag", 32'h0);     check_output(32'(IRQ));
    @(negedge CLK);
    expect_val("irq_set", 32'h1);     check_output(32'(IRQ));
    do_load(A_CHG);
    expect_val("chg_set", 32'h01);    check_output(32'(bus.RDATA));

    $display("[TB] write-1-to-clear race with new change");
    IN_PORTS[7:0] = 8'h5A;
    @(negedge CLK);
    do_store(A_CHG, 8'h01);
    expect_val("irq_race", 32'h1); check_output(32'(IRQ));
    do_load(A_CHG);
    expect_val("chg_race", 32'h01); check_output(32'(bus.RDATA));
    expect_val("irq_race2", 32'h1); check_output(32'(IRQ));
    do_store(A_CHG, 8'h01);
    do_load(A_CHG);
    expect_val("chg_cleared", 32'h00); check_output(32'(bus.RDATA));
    expect_val("irq_cleared", 32'h0);  check_output(32'(IRQ));

    $display("[TB] out-of-window accesses");
    do_load(A_OUT1);
    expect_val("read_out1_again", 32'hA5); check_output(32'(bus.RDATA));
    @(negedge CLK);
    bus.ADDRESS = A_BELOW;
    bus.LOAD    = 1'b1;
    #1;
    expect_val("hit_below", 32'h0); check_output(32'(bus.HIT));
    @(negedge CLK);
    bus.LOAD = 1'b0;
    expect_val("rdata_below", 32'h00); check_output(32'(bus.RDATA));
    do_load(A_OUT1);
    @(negedge CLK);
    bus.ADDRESS = A_END;
    bus.LOAD    = 1'b1;
    #1;
    expect_val("hit_end", 32'h0); check_output(32'(bus.HIT));
    @(negedge CLK);
    bus.LOAD = 1'b0;
    expect_val("rdata_end", 32'h00); check_output(32'(bus.RDATA));
    do_store(A_BELOW, 8'hFF);
    do_store(A_END, 8'hFF);
    expect_val("out_unchanged", 32'h22A511); check_output(32'(OUT_PORTS));
    do_load(A_IEN);
    expect_val("ien_unchanged", 32'h01); check_output(32'(bus.RDATA));

    $display("[TB] store to input address is ignored");
    do_store(A_IN0, 8'h00);
    do_load(A_IN0);
    expect_val("in0_no_store", 32'h5A); check_output(32'(bus.RDATA));

    $display("[TB] simultaneous load and store");
    do_load(A_OUT1);
    @(negedge CLK);
    bus.ADDRESS = A_OUT0;
    bus.WDATA   = 8'h77;
    bus.STORE   = 1'b1;
    bus.LOAD    = 1'b1;
    @(negedge CLK);
    bus.STORE = 1'b0;
    bus.LOAD  = 1'b0;
    expect_val("dual_out0", 32'h22A577); check_output(32'(OUT_PORTS));
    expect_val("dual_rdata", 32'hA5);    check_output(32'(bus.RDATA));

    $display("[TB] asynchronous reset mid-operation");
    do_store(A_OUT0, 8'hFF);
    IN_PORTS = 16'hC300;
    repeat (4) @(negedge CLK);
    do_load(A_CHG);
    expect_val("chg_both", 32'h03);  check_output(32'(bus.RDATA));
    expect_val("irq_before", 32'h1); check_output(32'(IRQ));
    @(posedge CLK);
    #3;
    bus.ADDRESS = A_OUT1;
    bus.WDATA   = 8'h99;
    bus.STORE   = 1'b1;
    RESET       = 1'b0;
    #1;
    expect_val("async_out", 32'h0);   check_output(32'(OUT_PORTS));
    expect_val("async_rdata", 32'h0); check_output(32'(bus.RDATA));
    expect_val("async_irq", 32'h0);   check_output(32'(IRQ));
    @(negedge CLK);
    bus.STORE = 1'b0;

    $display("[TB] change flag from nonzero input at reset release");
    RESET = 1'b1;
    @(negedge CLK);
    do_load(A_CHG);
    expect_val("chg_release_early", 32'h00); check_output(32'(bus.RDATA));
    do_load(A_CHG);
    expect_val("chg_release", 32'h02);       check_output(32'(bus.RDATA));
    do_load(A_IEN);
    expect_val("ien_after_reset", 32'h00);   check_output(32'(bus.RDATA));
    expect_val("out_after_reset", 32'h0);    check_output(32'(OUT_PORTS));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_ports.md
MMIO_PORTS -- requirements
Module: mmio_ports

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of every port register and data bus.
REQ-002 SHALL have parameter ADDR_W, default 16: width of ADDRESS.
REQ-003 SHALL have parameter BASE_ADDR, default 16'hFF00: first address of the register window.
REQ-004 SHALL have parameter N_OUT, default 3, legal 1..8: number of output port registers.
REQ-005 SHALL have parameter N_IN, default 2, legal 1..DATA_W: number of input port channels.
REQ-006 SHALL have parameter SYNC_STAGES, default 2, legal 2..4: flip-flop stages per input synchronizer.
REQ-007 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-008 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port ADDRESS  input  ADDR_W  bus address from the register file.
REQ-010 SHALL have port WDATA  input  DATA_W  store data.
REQ-011 SHALL have port STORE  input  1  write strobe, one cycle per access.
REQ-012 SHALL have port LOAD  input  1  read strobe, one cycle per access.
REQ-013 SHALL have port RDATA  output  DATA_W  registered read data.
REQ-014 SHALL have port HIT  output  1  combinational: ADDRESS lies inside the window.
REQ-015 SHALL have port IN_PORTS  input  N_IN*DATA_W  asynchronous external inputs; channel k at bits [k*DATA_W +: DATA_W].
REQ-016 SHALL have port OUT_PORTS  output  N_OUT*DATA_W  output registers; channel k packed the same way.
REQ-017 SHALL have port IRQ  output  1  registered interrupt request.

Function
REQ-018 SHALL map the window as: OUT[k] at BASE_ADDR+k; IN[k] at BASE_ADDR+N_OUT+k; CHG at BASE_ADDR+N_OUT+N_IN; IEN at BASE_ADDR+N_OUT+N_IN+1. Window size is N_OUT+N_IN+2.
REQ-019 SHALL pass each IN_PORTS channel through SYNC_STAGES flip-flops, followed by one history register; the IN[k] read value is the last synchronizer stage.
REQ-020 SHALL set CHG bit k in the cycle where the synchronized IN[k] differs from its history register; CHG bits are sticky.
REQ-021 SHALL clear CHG bits on STORE to the CHG address with write-1-to-clear semantics; a set and a clear of the same bit in one cycle leaves the bit set.
REQ-022 SHALL read CHG bits at or above N_IN as 0 and ignore writes to them.
REQ-023 SHALL update OUT[k] on the first rising edge with STORE=1 and ADDRESS=OUT[k]; OUT_PORTS reflects the new value from that edge onward.
REQ-024 SHALL treat STORE to IN[k] addresses as a no-op.
REQ-025 SHALL store the IEN register on STORE to its address; IEN bits at or above N_IN read as 0.
REQ-026 SHALL register IRQ <= |(CHG & IEN) each cycle, giving a one-cycle lag after CHG or IEN changes.
REQ-027 SHALL load RDATA on the edge with LOAD=1, STORE=0 and HIT=1 (one-cycle read latency); on LOAD=1 with HIT=0, RDATA SHALL load 0; with LOAD=0, RDATA SHALL hold.
REQ-028 SHALL, when LOAD and STORE are both 1, perform the store only and hold RDATA.
REQ-029 SHALL not clear CHG bits on a read.
REQ-030 SHALL have no effect on any register for accesses with HIT=0.
REQ-031 SHALL compute window offsets modulo 2^ADDR_W, with no wrap past the window end.

Reset
REQ-032 SHALL, while RESET=0, asynchronously force OUT_PORTS=0, RDATA=0, CHG=0, IEN=0, IRQ=0, and all synchronizer and history flops to 0.
REQ-033 SHALL release reset on the first CLK edge after RESET rises.
REQ-034 SHALL abandon, with no partial update, an access that is in progress when reset asserts.
REQ-035 SHALL, when any input is nonzero at reset release, set the corresponding CHG bit SYNC_STAGES+1 cycles later.

Verification
REQ-036 Out port store/read: STORE 8'hA5 to BASE+1, then LOAD BASE+1 -> OUT_PORTS[15:8]=A5 after 1 edge; RDATA=A5 one cycle after LOAD.
REQ-037 Input change flag: IN_PORTS channel 0 goes 00->3C with IEN=01 -> IN[0] reads 3C after SYNC_STAGES edges; CHG=01 next edge; IRQ=1 one edge later.
REQ-038 W1C race: STORE 8'h01 to CHG in the same cycle channel 0 changes again -> CHG[0] stays 1 and IRQ stays 1.
REQ-039 Out-of-window access: LOAD at BASE-1 and at BASE+N_OUT+N_IN+2 -> HIT=0, RDATA=0, no register changes.
REQ-040 Simultaneous strobes: LOAD+STORE 8'h77 to BASE+0 -> OUT[0]=77 and RDATA unchanged.
REQ-041 Mid-operation reset: assert RESET=0 between CLK edges with OUT[0]=FF and CHG=03 -> all outputs 0 immediately, before any CLK edge.
